// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS control FSM; `define MIPS_CTRL_ILLEGAL_TRAP_EN makes unknown opcodes trap.
// Latency: 3-5 cycles per instruction, outputs are combinational decodes of state/Op/Funct.
// Backpressure: none; one instruction in flight, advances every cycle.
module mips_mc_ctrl #(
   parameter logic [3:0] RESET_STATE = 4'd0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] Op,
   input  logic [5:0] Funct,
   input  logic       Zero,
   output logic       PCWr,
   output logic       IRWr,
   output logic       RFWr,
   output logic       DMWr,
   output logic [1:0] EXTOp,
   output logic [1:0] ALUOp,
   output logic [1:0] NPCOp,
   output logic       BSel,
   output logic [1:0] WRSel,
   output logic [1:0] WDSel,
   output logic [3:0] state,
   output logic       done,
   output logic       illegal
);

   typedef enum logic [3:0] {
      FETCH  = 4'd0,  DECODE = 4'd1, EXE    = 4'd2, ALUWB = 4'd3,
      MADDR  = 4'd4,  MREAD  = 4'd5, MWB    = 4'd6, MWRITE = 4'd7,
      BRANCH = 4'd8,  JUMP   = 4'd9, TRAP   = 4'd10
   } state_t;

   state_t st;

   logic rtype, i_addu, i_subu, i_jr, i_ori, i_lui, i_lw, i_sw, i_beq, i_j, i_jal;
   logic is_alu, is_mem, is_jmp;

   assign rtype  = (Op == 6'b000000);
   assign i_addu = rtype && (Funct == 6'b100001);
   assign i_subu = rtype && (Funct == 6'b100011);
   assign i_jr   = rtype && (Funct == 6'b001000);
   assign i_ori  = (Op == 6'b001101);
   assign i_lui  = (Op == 6'b001111);
   assign i_lw   = (Op == 6'b100011);
   assign i_sw   = (Op == 6'b101011);
   assign i_beq  = (Op == 6'b000100);
   assign i_j    = (Op == 6'b000010);
   assign i_jal  = (Op == 6'b000011);

   assign is_alu = i_addu | i_subu | i_ori | i_lui;
   assign is_mem = i_lw | i_sw;
   assign is_jmp = i_j | i_jal | i_jr;

   assign state = st;

   always_ff @(posedge clk) begin
      if (rst) begin
         st <= state_t'(RESET_STATE);
      end else begin
         case (st)
            FETCH:  st <= DECODE;
            DECODE: begin
               if (is_alu)      st <= EXE;
               else if (is_mem) st <= MADDR;
               else if (i_beq)  st <= BRANCH;
               else if (is_jmp) st <= JUMP;
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
               else             st <= TRAP;
`else
               else             st <= FETCH;
`endif
            end
            EXE:    st <= ALUWB;
            MADDR:  st <= i_lw ? MREAD : (i_sw ? MWRITE : FETCH);
            MREAD:  st <= MWB;
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
            TRAP:   st <= TRAP;
`else
            TRAP:   st <= FETCH;
`endif
            default: st <= FETCH;
         endcase
      end
   end

   always_comb begin
      PCWr  = 1'b0;
      IRWr  = 1'b0;
      RFWr  = 1'b0;
      DMWr  = 1'b0;
      EXTOp = 2'b00;
      ALUOp = 2'b00;
      NPCOp = 2'b00;
      BSel  = 1'b0;
      WRSel = 2'b00;
      WDSel = 2'b00;
      done  = 1'b0;
      case (st)
         FETCH: begin
            PCWr = 1'b1;
            IRWr = 1'b1;
         end
         EXE: begin
            if (i_subu) ALUOp = 2'b01;
            if (i_ori || i_lui) begin
               ALUOp = 2'b10;
               BSel  = 1'b1;
               EXTOp = i_lui ? 2'b10 : 2'b00;
            end
         end
         ALUWB: begin
            RFWr  = 1'b1;
            WRSel = rtype ? 2'b01 : 2'b00;
            done  = 1'b1;
         end
         // The address stays on the ALU through MREAD/MWRITE so DM sees it stable.
         MADDR, MREAD: begin
            BSel  = 1'b1;
            EXTOp = 2'b01;
         end
         MWB: begin
            RFWr  = 1'b1;
            WDSel = 2'b01;
            done  = 1'b1;
         end
         MWRITE: begin
            DMWr  = 1'b1;
            BSel  = 1'b1;
            EXTOp = 2'b01;
            done  = 1'b1;
         end
         BRANCH: begin
            ALUOp = 2'b01;
            NPCOp = 2'b01;
            EXTOp = 2'b01;
            PCWr  = Zero;
            done  = 1'b1;
         end
         JUMP: begin
            PCWr  = 1'b1;
            done  = 1'b1;
            NPCOp = i_jr ? 2'b11 : 2'b10;
            // jal links the PC+4 already latched during FETCH.
            if (i_jal) begin
               RFWr  = 1'b1;
               WRSel = 2'b10;
               WDSel = 2'b10;
            end
         end
         default: ;
      endcase
   end

`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
   assign illegal = (st == TRAP);
`else
   assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Scoreboard bench for mips_mc_ctrl: expected per-cycle control vectors are queued per instruction.
module tb_mips_mc_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [5:0] Op, Funct;
   logic       Zero;
   logic       PCWr, IRWr, RFWr, DMWr, BSel, done, illegal;
   logic [1:0] EXTOp, ALUOp, NPCOp, WRSel, WDSel;
   logic [3:0] state;

   int errors = 0;
   int checks = 0;

   // {state, PCWr, IRWr, RFWr, DMWr, EXTOp, ALUOp, NPCOp, BSel, WRSel, WDSel, done, illegal}
   logic [20:0] obs;
   logic [20:0] sb[$];

   assign obs = {state, PCWr, IRWr, RFWr, DMWr, EXTOp, ALUOp, NPCOp, BSel, WRSel, WDSel, done, illegal};

   always #5 clk = ~clk;

   mips_mc_ctrl dut (
      .clk(clk), .rst(rst), .Op(Op), .Funct(Funct), .Zero(Zero),
      .PCWr(PCWr), .IRWr(IRWr), .RFWr(RFWr), .DMWr(DMWr),
      .EXTOp(EXTOp), .ALUOp(ALUOp), .NPCOp(NPCOp), .BSel(BSel),
      .WRSel(WRSel), .WDSel(WDSel), .state(state), .done(done), .illegal(illegal)
   );

   // instruction index: 0 addu 1 subu 2 ori 3 lui 4 lw 5 sw 6 beq 7 j 8 jal 9 jr
   logic [5:0] op_tab [10] = '{6'b000000, 6'b000000, 6'b001101, 6'b001111, 6'b100011,
                               6'b101011, 6'b000100, 6'b000010, 6'b000011, 6'b000000};
   logic [5:0] fn_tab [10] = '{6'b100001, 6'b100011, 6'b000000, 6'b000000, 6'b000000,
                               6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b001000};

   task automatic ex(input int s, input int pc, input int ir, input int rf, input int dm,
                     input int ext, input int alu, input int npc, input int b,
                     input int wr, input int wd, input int dn, input int il);
      sb.push_back({4'(s), 1'(pc), 1'(ir), 1'(rf), 1'(dm), 2'(ext), 2'(alu), 2'(npc),
                    1'(b), 2'(wr), 2'(wd), 1'(dn), 1'(il)});
   endtask

   task automatic push_instr(input int k, input logic z);
      Op    = op_tab[k];
      Funct = fn_tab[k];
      Zero  = z;
      ex(0, 1,1,0,0, 0,0,0, 0, 0,0, 0,0);
      ex(1, 0,0,0,0, 0,0,0, 0, 0,0, 0,0);
      case (k)
         0: begin ex(2, 0,0,0,0, 0,0,0, 0, 0,0, 0,0); ex(3, 0,0,1,0, 0,0,0, 0, 1,0, 1,0); end
         1: begin ex(2, 0,0,0,0, 0,1,0, 0, 0,0, 0,0); ex(3, 0,0,1,0, 0,0,0, 0, 1,0, 1,0); end
         2: begin ex(2, 0,0,0,0, 0,2,0, 1, 0,0, 0,0); ex(3, 0,0,1,0, 0,0,0, 0, 0,0, 1,0); end
         3: begin ex(2, 0,0,0,0, 2,2,0, 1, 0,0, 0,0); ex(3, 0,0,1,0, 0,0,0, 0, 0,0, 1,0); end
         4: begin
            ex(4, 0,0,0,0, 1,0,0, 1, 0,0, 0,0);
            ex(5, 0,0,0,0, 1,0,0, 1, 0,0, 0,0);
            ex(6, 0,0,1,0, 0,0,0, 0, 0,1, 1,0);
         end
         5: begin ex(4, 0,0,0,0, 1,0,0, 1, 0,0, 0,0); ex(7, 0,0,0,1, 1,0,0, 1, 0,0, 1,0); end
         6: ex(8, int'(z),0,0,0, 1,1,1, 0, 0,0, 1,0);
         7: ex(9, 1,0,0,0, 0,0,2, 0, 0,0, 1,0);
         8: ex(9, 1,0,1,0, 0,0,2, 0, 2,2, 1,0);
         default: ex(9, 1,0,0,0, 0,0,3, 0, 0,0, 1,0);
      endcase
   endtask

   task automatic test_reset();
      logic [20:0] e;
      rst = 1'b1;
      Op = 6'd0; Funct = 6'd0; Zero = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      ex(0, 1,1,0,0, 0,0,0, 0, 0,0, 0,0);
      ex(0, 1,1,0,0, 0,0,0, 0, 0,0, 0,0);
      while (sb.size() > 0) begin
         @(negedge clk);
         e = sb.pop_front();
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL reset got %h want %h", obs, e);
         end
         @(posedge clk); #1;
      end
      rst = 1'b0;
   endtask

   task automatic test_alu();
      logic [20:0] e;
      for (int k = 0; k < 4; k++) begin
         push_instr(k, 1'b1);   // Zero high must not leak into non-branch states
         while (sb.size() > 0) begin
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
               errors++;
               $display("FAIL alu k=%0d got %h want %h", k, obs, e);
            end
            @(posedge clk); #1;
         end
      end
   endtask

   task automatic test_mem();
      logic [20:0] e;
      int dm_cnt;
      for (int k = 4; k < 6; k++) begin
         push_instr(k, 1'b0);
         dm_cnt = 0;
         while (sb.size() > 0) begin
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (DMWr === 1'b1) dm_cnt++;
            if (obs !== e) begin
               errors++;
               $display("FAIL mem k=%0d got %h want %h", k, obs, e);
            end
            @(posedge clk); #1;
         end
         checks++;
         if (dm_cnt !== ((k == 5) ? 1 : 0)) begin
            errors++;
            $display("FAIL mem_dmwr_count k=%0d got %0d want %0d", k, dm_cnt, (k == 5) ? 1 : 0);
         end
      end
   endtask

   task automatic test_branch_jump();
      logic [20:0] e;
      int ks [5] = '{6, 6, 7, 8, 9};
      logic zs [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      for (int i = 0; i < 5; i++) begin
         push_instr(ks[i], zs[i]);
         while (sb.size() > 0) begin
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
               errors++;
               $display("FAIL branch_jump k=%0d got %h want %h", ks[i], obs, e);
            end
            @(posedge clk); #1;
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [20:0] e;
      push_instr(4, 1'b0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         e = sb.pop_front();
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL reset_mid pre cyc%0d got %h want %h", i, obs, e);
         end
         if (i == 3) rst = 1'b1;   // sampled on the edge leaving MREAD
         @(posedge clk); #1;
      end
      rst = 1'b0;
      sb.delete();
      push_instr(4, 1'b0);
      while (sb.size() > 0) begin
         @(negedge clk);
         e = sb.pop_front();
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL reset_mid post got %h want %h", obs, e);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_illegal();
      logic [20:0] e;
      Op = 6'b111111; Funct = 6'b000000; Zero = 1'b0;
      ex(0, 1,1,0,0, 0,0,0, 0, 0,0, 0,0);
      ex(1, 0,0,0,0, 0,0,0, 0, 0,0, 0,0);
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
      repeat (12) ex(10, 0,0,0,0, 0,0,0, 0, 0,0, 0,1);
`else
      ex(0, 1,1,0,0, 0,0,0, 0, 0,0, 0,0);
`endif
      while (sb.size() > 0) begin
         @(negedge clk);
         e = sb.pop_front();
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL illegal got %h want %h", obs, e);
         end
         @(posedge clk); #1;
      end
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (obs !== {4'd0, 1'b1, 1'b1, 15'd0}) begin
         errors++;
         $display("FAIL illegal_exit got %h want %h", obs, {4'd0, 1'b1, 1'b1, 15'd0});
      end
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
`else
      // one FETCH cycle consumed above; re-align into FETCH
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
`endif
   endtask

   task automatic test_back_to_back();
      logic [20:0] e;
      int k;
      for (int n = 0; n < 40; n++) begin
         k = $urandom_range(0, 9);
         push_instr(k, 1'($urandom_range(0, 1)));
         while (sb.size() > 0) begin
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
               errors++;
               $display("FAIL b2b n=%0d k=%0d got %h want %h", n, k, obs, e);
            end
            if (RFWr === 1'b1 && DMWr === 1'b1) begin
               errors++;
               $display("FAIL b2b_rf_dm_excl got RFWr=1 DMWr=1 want at most one");
            end
            @(posedge clk); #1;
         end
      end
   endtask

   initial begin
      test_reset();
      test_alu();
      test_mem();
      test_branch_jump();
      test_reset_mid();
      test_illegal();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got running want finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/mips_mc_ctrl.md
Name: mips_mc_ctrl

Overview:
- Multicycle control FSM for the single-issue MIPS core.
- Sequences the PC, IM/IR, RF, ALU, DM and NPC datapath by decoding the latched instruction's Op/Funct.
- Drives every write enable and mux select.
- Instructions take 3–5 cycles; one instruction is in flight at a time.

Parameters:
- RESET_STATE, 4'd0, state code loaded on reset (FETCH).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous active-high reset.
- Op  in  6  instr[31:26] from IR.
- Funct  in  6  instr[5:0] from IR.
- Zero  in  1  ALU zero flag.
- PCWr  out  1  PC write enable.
- IRWr  out  1  IR write enable.
- RFWr  out  1  register file write enable.
- DMWr  out  1  data memory write enable.
- EXTOp  out  2  00 zero-ext, 01 sign-ext, 10 imm<<16.
- ALUOp  out  2  00 add, 01 sub, 10 or, 11 reserved.
- NPCOp  out  2  00 PC+4, 01 branch (PC+4+simm<<2), 10 jump (imm26), 11 jr (RD1).
- BSel  out  1  ALU B: 0 RD2, 1 EXT.
- WRSel  out  2  A3: 00 rt, 01 rd, 10 r31.
- WDSel  out  2  WD: 00 ALU, 01 DM, 10 PC (link).
- state  out  4  current state, for debug.
- done  out  1  1-cycle pulse in an instruction's final cycle.
- illegal  out  1  unknown opcode flag (see Optional Feature).

Behaviour:
- Clock and reset: one clock domain, clk. rst is synchronous and active-high; it is sampled only on the rising edge of clk.
- States:
  - FETCH=0, DECODE=1, EXE=2, ALUWB=3, MADDR=4, MREAD=5, MWB=6, MWRITE=7, BRANCH=8, JUMP=9, TRAP=10.
  - Codes 11–15 go to FETCH.
- Output style: all outputs are combinational Moore decodes of state plus Op/Funct. The IR holds Op/Funct stable after FETCH.
- Defaults: every enable is 0 and every select is 00 unless listed below.
- FETCH:
  - Outputs: PCWr=1, IRWr=1, NPCOp=00.
  - Next state: DECODE.
- DECODE: no writes. Next state by decoded instruction:
  - addu (Op 0, Funct 100001), subu (Op 0, Funct 100011), ori (001101), lui (001111) -> EXE.
  - lw (100011), sw (101011) -> MADDR.
  - beq (000100) -> BRANCH.
  - j (000010), jal (000011), jr (Op 0, Funct 001000) -> JUMP.
  - Anything else -> TRAP if the feature is enabled, otherwise FETCH.
- EXE:
  - addu: ALUOp=00, BSel=0.
  - subu: ALUOp=01, BSel=0.
  - ori: ALUOp=10, BSel=1, EXTOp=00.
  - lui: ALUOp=10, BSel=1, EXTOp=10 (rs is r0 by encoding).
  - Next state: ALUWB.
- ALUWB:
  - RFWr=1, WDSel=00, done=1.
  - WRSel=01 for R-type, 00 otherwise.
  - Next state: FETCH.
- MADDR:
  - ALUOp=00, BSel=1, EXTOp=01.
  - Next state: MREAD for lw, MWRITE for sw.
- MREAD: address held (same ALU controls as MADDR). Next state: MWB.
- MWB:
  - RFWr=1, WRSel=00, WDSel=01, done=1.
  - Next state: FETCH.
- MWRITE:
  - DMWr=1, ALU controls as MADDR, done=1.
  - Next state: FETCH.
- BRANCH:
  - ALUOp=01, BSel=0, NPCOp=01, EXTOp=01.
  - PCWr=Zero, done=1.
  - Next state: FETCH.
- JUMP, all variants: PCWr=1, done=1, next state FETCH.
  - j: NPCOp=10.
  - jr: NPCOp=11.
  - jal: NPCOp=10, plus RFWr=1, WRSel=10, WDSel=10 in the same cycle. The PC value written to r31 is the PC+4 already latched in FETCH.
- Latency:
  - R-type/ori/lui: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - beq, j, jal, jr: 3 cycles.
- Reset:
  - rst=1 at any edge, including mid-instruction: state<=FETCH and the TRAP latch is cleared.
  - Any in-progress RF/DM write from that cycle is not suppressed; it is ignored by spec.
  - Outputs reflect FETCH in the first cycle after reset.
- Simultaneous events:
  - rst has priority over all transitions.
  - Zero is sampled only in BRANCH.
- No more than one of RFWr/DMWr is ever 1 in the same cycle.

Optional Feature:
- Macro: MIPS_CTRL_ILLEGAL_TRAP_EN.
- Defined:
  - An unknown opcode/funct in DECODE goes to TRAP.
  - TRAP holds all enables 0 and illegal=1, and stays there until rst.
- Undefined:
  - An unknown opcode is treated as a NOP: DECODE -> FETCH, 2 cycles, done not pulsed.
  - The TRAP state is unreachable; illegal is tied 0.

Test Plan:
- Reset, then addu (Op 0, Funct 100001) -> state sequence 0,1,2,3,0. RFWr=1 and WRSel=01 only in state 3. PCWr=1 only in state 0.
- lw then sw -> lw: 5 cycles, RFWr+WDSel=01 in MWB. sw: 4 cycles, DMWr=1 exactly one cycle, EXTOp=01/BSel=1 in MADDR.
- beq with Zero=1, then beq with Zero=0 -> PCWr=1 with NPCOp=01 in BRANCH in the first case, PCWr=0 in the second. Both take 3 cycles.
- jal -> JUMP cycle has PCWr=1, NPCOp=10, RFWr=1, WRSel=10, WDSel=10. jr -> NPCOp=11, RFWr=0.
- rst=1 asserted while in MREAD -> state=0 next cycle. Outputs PCWr=1/IRWr=1 on the following cycle.
- Op=111111 -> with macro: TRAP, illegal=1 held 10+ cycles, no enables, exits only on rst. Without macro: back to FETCH after DECODE, illegal=0.
